// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd_seq
// Description : Multi-cycle signed binary-to-BCD converter. Serial
//               double-dabble, one operand bit per clock, with a
//               start/busy/done handshake. Feeds bcd2disp sign/bcd inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic             sign,
    output logic [3:0]       bcd [DIGITS]
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int             c_SW       = 4 * DIGITS;        // scratch width
    localparam int             c_CW       = $clog2(WIDTH + 1); // counter width
    localparam logic [c_CW-1:0] c_CNT_INIT = c_CW'(WIDTH);
    localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]       r_state;
    logic [c_CW-1:0]  r_cnt;
    logic [WIDTH-1:0] r_mag;
    logic             r_neg;
    logic [c_SW-1:0]  r_scr;
    logic             r_sign;
    logic [c_SW-1:0]  r_bcd;

    logic             w_accept;
    logic             w_last;
    logic             w_neg_in;
    logic [WIDTH-1:0] w_mag_in;
    logic [c_SW-1:0]  w_adj;
    logic [c_SW-1:0]  w_scr_next;
    logic [WIDTH-1:0] w_mag_next;

    // Operand capture: the most negative value negates to 2^(WIDTH-1), which
    // still fits because the magnitude is treated as unsigned.
    assign w_neg_in = bin[WIDTH-1];
    assign w_mag_in = w_neg_in ? ({WIDTH{1'b0}} - bin) : bin;

    assign w_accept = (r_state == c_IDLE) && start;
    assign w_last   = (r_cnt == c_CNT_ONE);

    // Double-dabble correction: every digit of 5 or more gets +3 before the shift
    always_comb begin
        w_adj = r_scr;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_scr[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_scr[4*i +: 4] + 4'd3;
            end
        end
    end

    // The magnitude MSB enters digit 0; the top digit's carry falls off the end
    assign w_scr_next = {w_adj[c_SW-2:0], r_mag[WIDTH-1]};
    assign w_mag_next = {r_mag[WIDTH-2:0], 1'b0};

    // Control FSM: IDLE -> SHIFT (WIDTH cycles) -> DONE (one cycle) -> IDLE
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_cnt   <= c_CNT_INIT;
                        r_state <= c_SHIFT;
                    end
                end
                c_SHIFT: begin
                    r_cnt <= r_cnt - c_CNT_ONE;
                    if (w_last) begin
                        r_state <= c_DONE;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // Conversion datapath: capture operand on accept, shift while converting
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_neg <= 1'b0;
            r_mag <= '0;
            r_scr <= '0;
        end else if (w_accept) begin
            r_neg <= w_neg_in;
            r_mag <= w_mag_in;
            r_scr <= '0;
        end else if (r_state == c_SHIFT) begin
            r_mag <= w_mag_next;
            r_scr <= w_scr_next;
        end
    end

    // Result registers: loaded only on entry to DONE, so the previous result
    // stays visible for the whole of the next conversion
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sign <= 1'b0;
            r_bcd  <= '0;
        end else if ((r_state == c_SHIFT) && w_last) begin
            r_sign <= r_neg;
            r_bcd  <= w_scr_next;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign busy = (r_state == c_SHIFT) || (r_state == c_DONE);
    assign done = (r_state == c_DONE);
    assign sign = r_sign;

    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_bcd_out
            assign bcd[g] = r_bcd[4*g +: 4];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_bin2bcd_seq
// Description : Self-checking bench for bin2bcd_seq (WIDTH=32, DIGITS=16).
//               Expected results come from an arithmetic decimal model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bin2bcd_seq;

    localparam int W  = 32;
    localparam int ND = 16;

    logic          clk;
    logic          reset_n;
    logic          start;
    logic [W-1:0]  bin;
    logic          busy;
    logic          done;
    logic          sign;
    logic [3:0]    bcd [ND];
    logic [4*ND-1:0] act_bcd;

    int checks   = 0;
    int failures = 0;

    bin2bcd_seq #(.WIDTH(W), .DIGITS(ND)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (start),
        .bin    (bin),
        .busy   (busy),
        .done   (done),
        .sign   (sign),
        .bcd    (bcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flatten the digit array so a whole result prints as one hex word
    always_comb begin
        act_bcd = '0;
        for (int i = 0; i < ND; i++) act_bcd[4*i +: 4] = bcd[i];
    end

    // Decimal reference: sign from the MSB, magnitude by plain arithmetic
    function automatic void model(input logic [W-1:0] b, output logic s,
                                  output logic [4*ND-1:0] d);
        longint unsigned m;
        s = b[W-1];
        m = {32'd0, b};
        if (s) m = 64'h1_0000_0000 - m;
        d = '0;
        for (int i = 0; i < ND; i++) begin
            d[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
    endfunction

    // Advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start one conversion and wait (bounded) for done. lat counts sampled
    // cycles from the accepting edge, so done in cycle WIDTH+1 gives lat=33.
    task automatic run_conv(input logic [W-1:0] b, output int lat,
                            output bit got, output bit busy_ok);
        bin   = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        bin   = $urandom;          // operand changes while busy are ignored
        lat     = 1;
        got     = 1'b0;
        busy_ok = 1'b1;
        for (int k = 0; k < 60; k++) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (done === 1'b1) begin
                got = 1'b1;
                break;
            end
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start   = 1'b1;
        bin     = 32'd777;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({busy, done, sign} !== 3'b000 || act_bcd !== '0) begin
                failures++;
                $display("FAIL reset_state: busy=%b done=%b sign=%b bcd=%h, required 0/0/0/0",
                         busy, done, sign, act_bcd);
            end
        end
        start   = 1'b0;
        reset_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_conv: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_zero();
        int lat; bit got; bit bok;
        run_conv(32'd0, lat, got, bok);
        checks++;
        if (!got || lat != W + 1) begin
            failures++;
            $display("FAIL zero_latency: got_done=%0d lat=%0d, required 1/%0d", got, lat, W + 1);
        end
        checks++;
        if (sign !== 1'b0 || act_bcd !== '0) begin
            failures++;
            $display("FAIL zero_result: sign=%b bcd=%h, required 0/0", sign, act_bcd);
        end
        checks++;
        if (!bok) begin
            failures++;
            $display("FAIL zero_busy: busy dropped during conversion, required high");
        end
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL zero_after: busy=%b done=%b, required 0/0", busy, done);
        end
    endtask

    task automatic test_known();
        int lat; bit got; bit bok;
        logic [W-1:0]    vals [3] = '{32'd1234567890, 32'hFFFFFFFF, 32'h80000000};
        logic            exps [3] = '{1'b0, 1'b1, 1'b1};
        logic [4*ND-1:0] expd [3] = '{64'h0000_0012_3456_7890,
                                      64'h0000_0000_0000_0001,
                                      64'h0000_0021_4748_3648};
        for (int i = 0; i < 3; i++) begin
            run_conv(vals[i], lat, got, bok);
            checks++;
            if (!got || sign !== exps[i] || act_bcd !== expd[i]) begin
                failures++;
                $display("FAIL known_%0d: bin=%h done=%0d sign=%b bcd=%h, required sign=%b bcd=%h",
                         i, vals[i], got, sign, act_bcd, exps[i], expd[i]);
            end
            tick();
        end
    endtask

    task automatic test_ignore_start();
        logic [W-1:0]    a = 32'd31415926;
        logic            es;
        logic [4*ND-1:0] ed;
        logic            rs;
        logic [4*ND-1:0] rd;
        int              ndone = 0;
        model(a, es, ed);
        rs = 1'b0; rd = '0;
        bin   = a;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 45; c++) begin
            if (done === 1'b1) begin
                ndone++;
                rs = sign;
                rd = act_bcd;
            end
            if (c == 5 || c == 20) begin
                start = 1'b1;
                bin   = 32'hFFFF0000 ^ $urandom;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        checks++;
        if (ndone != 1) begin
            failures++;
            $display("FAIL ignore_count: done pulses=%0d, required 1", ndone);
        end
        checks++;
        if (rs !== es || rd !== ed) begin
            failures++;
            $display("FAIL ignore_result: sign=%b bcd=%h, required sign=%b bcd=%h", rs, rd, es, ed);
        end
    endtask

    task automatic test_continuous();
        logic [W-1:0]    vals [4];
        logic            es;
        logic [4*ND-1:0] ed;
        int              idx [4];
        int              n = 0;
        for (int i = 0; i < 4; i++) vals[i] = $urandom;
        bin   = vals[0];
        start = 1'b1;
        for (int c = 1; c <= 110; c++) begin
            tick();
            if (done === 1'b1 && n < 4) begin
                model(vals[n], es, ed);
                checks++;
                if (sign !== es || act_bcd !== ed) begin
                    failures++;
                    $display("FAIL cont_result_%0d: sign=%b bcd=%h, required sign=%b bcd=%h",
                             n, sign, act_bcd, es, ed);
                end
                idx[n] = c;
                n++;
                if (n < 4) bin = vals[n];
            end
        end
        start = 1'b0;
        checks++;
        if (n != 3) begin
            failures++;
            $display("FAIL cont_count: done pulses=%0d, required 3", n);
        end else begin
            checks++;
            if (idx[1] - idx[0] != W + 2 || idx[2] - idx[1] != W + 2) begin
                failures++;
                $display("FAIL cont_period: intervals %0d,%0d, required %0d",
                         idx[1] - idx[0], idx[2] - idx[1], W + 2);
            end
        end
        for (int k = 0; k < 50 && busy === 1'b1; k++) tick();
        tick();
    endtask

    task automatic test_reset_abort();
        int lat; bit got; bit bok;
        int ndone = 0;
        run_conv(32'd987654321, lat, got, bok);
        tick();
        bin   = 32'd12345;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 10; c++) tick();
        reset_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, sign} !== 3'b000 || act_bcd !== '0) begin
            failures++;
            $display("FAIL abort_state: busy=%b done=%b sign=%b bcd=%h, required 0/0/0/0",
                     busy, done, sign, act_bcd);
        end
        tick();
        reset_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (done === 1'b1) ndone++;
        end
        checks++;
        if (ndone != 0) begin
            failures++;
            $display("FAIL abort_no_done: done pulses=%0d, required 0", ndone);
        end
        run_conv(32'd42, lat, got, bok);
        checks++;
        if (!got || lat != W + 1 || sign !== 1'b0 || act_bcd !== 64'h42) begin
            failures++;
            $display("FAIL abort_restart: done=%0d lat=%0d sign=%b bcd=%h, required 1/%0d/0/42",
                     got, lat, sign, act_bcd, W + 1);
        end
        tick();
    endtask

    task automatic test_random();
        int lat; bit got; bit bok;
        logic            es;
        logic [4*ND-1:0] ed;
        logic [W-1:0]    b;
        logic [W-1:0]    edge_vals [6] = '{32'h7FFFFFFF, 32'h80000001, 32'd1,
                                          32'd9, 32'd10, 32'd99999999};
        for (int i = 0; i < 26; i++) begin
            b = (i < 6) ? edge_vals[i] : W'($urandom);
            model(b, es, ed);
            run_conv(b, lat, got, bok);
            checks++;
            if (!got || !bok || lat != W + 1 || sign !== es || act_bcd !== ed) begin
                failures++;
                $display("FAIL random_%0d: bin=%h done=%0d busy_ok=%0d lat=%0d sign=%b bcd=%h, required sign=%b bcd=%h",
                         i, b, got, bok, lat, sign, act_bcd, es, ed);
            end
            tick();
            checks++;
            if (done !== 1'b0 || sign !== es || act_bcd !== ed) begin
                failures++;
                $display("FAIL random_hold_%0d: done=%b sign=%b bcd=%h, required 0/%b/%h",
                         i, done, sign, act_bcd, es, ed);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        bin     = '0;
        test_reset();
        test_zero();
        test_known();
        test_ignore_start();
        test_continuous();
        test_reset_abort();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
